// File: rtl/mano_fetch_ctrl_pkg.sv
// Shared definitions for the Basic Computer fetch controller: bus-select codes,
// FSM states, the registered strobe bundle and small decode helpers.
package mano_pkg;

  localparam logic [2:0] SEL_NONE = 3'd0;
  localparam logic [2:0] SEL_AR   = 3'd1;
  localparam logic [2:0] SEL_PC   = 3'd2;
  localparam logic [2:0] SEL_DR   = 3'd3;
  localparam logic [2:0] SEL_AC   = 3'd4;
  localparam logic [2:0] SEL_IR   = 3'd5;
  localparam logic [2:0] SEL_TR   = 3'd6;
  localparam logic [2:0] SEL_MEM  = 3'd7;

  localparam int D7_REGIO = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_EXEC
  } state_t;

  typedef struct packed {
    logic [2:0] bus_sel;
    logic       mem_rd;
    logic       ar_ld;
    logic       pc_inr;
    logic       ir_ld;
    logic       exec_req;
  } ctrl_t;

  // Strobe pattern for a given state; indirect only matters in T3.
  function automatic ctrl_t decode_ctrl(input state_t st, input logic indirect);
    ctrl_t c;
    c = '0;
    case (st)
      ST_T0: begin
        c.bus_sel = SEL_PC;
        c.ar_ld   = 1'b1;
      end
      ST_T1: begin
        c.bus_sel = SEL_MEM;
        c.mem_rd  = 1'b1;
        c.ir_ld   = 1'b1;
        c.pc_inr  = 1'b1;
      end
      ST_T2: begin
        c.bus_sel = SEL_IR;
        c.ar_ld   = 1'b1;
      end
      ST_T3: begin
        if (indirect) begin
          c.bus_sel = SEL_MEM;
          c.mem_rd  = 1'b1;
          c.ar_ld   = 1'b1;
        end
      end
      ST_EXEC: c.exec_req = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] onehot3(input logic [2:0] v);
    return 8'b0000_0001 << v;
  endfunction

endpackage

// File: rtl/mano_fetch_ctrl_if.sv
// Control-side bundle between the fetch controller and the rest of the
// Basic Computer datapath / execute logic.
interface mano_fetch_ctrl_if;
  logic        RUN;
  logic [15:0] IR_Q;
  logic        EXEC_DONE;
  logic [2:0]  BUS_SEL;
  logic        MEM_RD;
  logic        AR_LD;
  logic        PC_INR;
  logic        IR_LD;
  logic [3:0]  SC;
  logic [7:0]  D;
  logic        I;
  logic        EXEC_REQ;
  logic        SC_OVF;

  modport master (
    input  RUN, IR_Q, EXEC_DONE,
    output BUS_SEL, MEM_RD, AR_LD, PC_INR, IR_LD, SC, D, I, EXEC_REQ, SC_OVF
  );

  modport slave (
    output RUN, IR_Q, EXEC_DONE,
    input  BUS_SEL, MEM_RD, AR_LD, PC_INR, IR_LD, SC, D, I, EXEC_REQ, SC_OVF
  );
endinterface

// File: rtl/mano_fetch_ctrl_sc4.sv
// 4-bit sequence counter: clear has priority, increment saturates at 15.
module mano_sc4 (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CLR,
  input  logic       INR,
  output logic [3:0] Q,
  output logic       SAT
);

  logic [3:0] count_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_reg <= 4'd0;
    end else if (CLR) begin
      count_reg <= 4'd0;
    end else if (INR && !SAT) begin
      count_reg <= count_reg + 4'd1;
    end
  end

  assign Q   = count_reg;
  assign SAT = (count_reg == 4'hF);

endmodule

// File: rtl/mano_fetch_ctrl.sv
// Fetch/decode/indirect sequencer for the Basic Computer; strobes are
// registered from the next state so they are clean for a whole T-state.
module mano_fetch_ctrl
  import mano_pkg::*;
(
  input  logic               CLK,
  input  logic               RST_N,
  mano_fetch_ctrl_if.master  bus
);

  state_t     state_reg, state_next;
  ctrl_t      ctrl_reg, ctrl_next;
  logic [7:0] d_reg;
  logic       i_reg;
  logic       ovf_reg;
  logic       ind_next;
  logic       sc_clr, sc_inr, sc_sat;
  logic [3:0] sc_q;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (bus.RUN) state_next = ST_T0;
      ST_T0:   state_next = ST_T1;
      ST_T1:   state_next = ST_T2;
      ST_T2:   state_next = ST_T3;
      ST_T3:   state_next = ST_EXEC;
      ST_EXEC: if (bus.EXEC_DONE) state_next = bus.RUN ? ST_T0 : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // T3 is only ever entered from T2, when IR_Q already holds the new word,
  // so the indirect decision is taken from IR_Q rather than the D/I registers.
  assign ind_next  = bus.IR_Q[15] && (bus.IR_Q[14:12] != 3'(D7_REGIO));
  assign ctrl_next = decode_ctrl(state_next, ind_next);

  assign sc_clr = (state_next == ST_IDLE) || (state_next == ST_T0);
  assign sc_inr = !sc_clr;

  mano_sc4 u_sc (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CLR   (sc_clr),
    .INR   (sc_inr),
    .Q     (sc_q),
    .SAT   (sc_sat)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= ST_IDLE;
      ctrl_reg  <= '0;
      d_reg     <= 8'd0;
      i_reg     <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= ctrl_next;
      if (state_reg == ST_T2) begin
        d_reg <= onehot3(bus.IR_Q[14:12]);
        i_reg <= bus.IR_Q[15];
      end
      // Flag in the same cycle SC lands on 15 so it lines up with the counter.
      if (state_reg == ST_EXEC && !bus.EXEC_DONE && (sc_q == 4'd14 || sc_sat)) begin
        ovf_reg <= 1'b1;
      end
    end
  end

  assign bus.BUS_SEL  = ctrl_reg.bus_sel;
  assign bus.MEM_RD   = ctrl_reg.mem_rd;
  assign bus.AR_LD    = ctrl_reg.ar_ld;
  assign bus.PC_INR   = ctrl_reg.pc_inr;
  assign bus.IR_LD    = ctrl_reg.ir_ld;
  assign bus.EXEC_REQ = ctrl_reg.exec_req;
  assign bus.SC       = sc_q;
  assign bus.D        = d_reg;
  assign bus.I        = i_reg;
  assign bus.SC_OVF   = ovf_reg;

endmodule

// File: tb/tb_mano_fetch_ctrl.sv
// Directed bench for mano_fetch_ctrl: walks reset, direct/indirect/register
// fetches, RUN drop and SC overflow with hand-computed strobe patterns.
module tb_mano_fetch_ctrl;

  logic CLK = 1'b0;
  logic RST_N;

  always #5 CLK = ~CLK;

  mano_fetch_ctrl_if bus ();

  mano_fetch_ctrl dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  // {BUS_SEL, MEM_RD, AR_LD, PC_INR, IR_LD, EXEC_REQ}
  localparam logic [7:0] C_NONE = 8'h00;
  localparam logic [7:0] C_T0   = 8'h48;
  localparam logic [7:0] C_T1   = 8'hF6;
  localparam logic [7:0] C_T2   = 8'hA8;
  localparam logic [7:0] C_T3I  = 8'hF8;
  localparam logic [7:0] C_EXEC = 8'h01;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ctl_obs();
    return {bus.BUS_SEL, bus.MEM_RD, bus.AR_LD, bus.PC_INR, bus.IR_LD, bus.EXEC_REQ};
  endfunction

  task automatic step_expect(input string tag, input logic [7:0] exp_ctl, input logic [3:0] exp_sc);
    @(posedge CLK);
    #1;
    $display("cycle %-10s ctl=%h sc=%0d D=%h I=%0d ovf=%0d", tag, ctl_obs(), bus.SC, bus.D, bus.I, bus.SC_OVF);
    check({tag, ".ctl"}, {8'h00, ctl_obs()}, {8'h00, exp_ctl});
    check({tag, ".sc"}, {12'h000, bus.SC}, {12'h000, exp_sc});
  endtask

  task automatic check_di(input string tag, input logic [7:0] exp_d, input logic exp_i);
    check({tag, ".D"}, {8'h00, bus.D}, {8'h00, exp_d});
    check({tag, ".I"}, {15'h0000, bus.I}, {15'h0000, exp_i});
  endtask

  initial begin
    RST_N         = 1'b0;
    bus.RUN       = 1'b0;
    bus.IR_Q      = 16'h2123;
    bus.EXEC_DONE = 1'b0;

    #12;
    check("rst.ctl", {8'h00, ctl_obs()}, 16'h0000);
    check("rst.sc", {12'h000, bus.SC}, 16'h0000);
    check_di("rst", 8'h00, 1'b0);
    check("rst.ovf", {15'h0000, bus.SC_OVF}, 16'h0000);

    @(negedge CLK);
    RST_N   = 1'b1;
    bus.RUN = 1'b1;
    step_expect("pre.t0", C_T0, 4'd0);
    step_expect("pre.t1", C_T1, 4'd1);

    // asynchronous reset in the middle of T1
    #1 RST_N = 1'b0;
    #1;
    check("midrst.ctl", {8'h00, ctl_obs()}, 16'h0000);
    check("midrst.sc", {12'h000, bus.SC}, 16'h0000);
    #1 RST_N = 1'b1;
    step_expect("rel.t0", C_T0, 4'd0);

    // direct LDA, EXEC_DONE on SC=5
    step_expect("lda.t1", C_T1, 4'd1);
    step_expect("lda.t2", C_T2, 4'd2);
    step_expect("lda.t3", C_NONE, 4'd3);
    check_di("lda", 8'h04, 1'b0);
    step_expect("lda.e4", C_EXEC, 4'd4);
    step_expect("lda.e5", C_EXEC, 4'd5);
    bus.EXEC_DONE = 1'b1;
    step_expect("lda.next", C_T0, 4'd0);
    bus.EXEC_DONE = 1'b0;

    // indirect LDA, minimum-length instruction
    bus.IR_Q = 16'hA123;
    step_expect("ind.t1", C_T1, 4'd1);
    step_expect("ind.t2", C_T2, 4'd2);
    step_expect("ind.t3", C_T3I, 4'd3);
    check_di("ind", 8'h04, 1'b1);
    step_expect("ind.e4", C_EXEC, 4'd4);
    bus.EXEC_DONE = 1'b1;
    step_expect("ind.next", C_T0, 4'd0);
    bus.EXEC_DONE = 1'b0;

    // register-reference with I=1: no indirect cycle
    bus.IR_Q = 16'hF800;
    step_expect("reg.t1", C_T1, 4'd1);
    check_di("reg.hold", 8'h04, 1'b1);
    step_expect("reg.t2", C_T2, 4'd2);
    step_expect("reg.t3", C_NONE, 4'd3);
    check_di("reg", 8'h80, 1'b1);
    step_expect("reg.e4", C_EXEC, 4'd4);
    bus.EXEC_DONE = 1'b1;
    step_expect("reg.next", C_T0, 4'd0);
    bus.EXEC_DONE = 1'b0;

    // RUN dropped during T1: fetch completes, then IDLE
    bus.IR_Q = 16'h2123;
    step_expect("halt.t1", C_T1, 4'd1);
    bus.RUN = 1'b0;
    step_expect("halt.t2", C_T2, 4'd2);
    step_expect("halt.t3", C_NONE, 4'd3);
    check_di("halt", 8'h04, 1'b0);
    step_expect("halt.e4", C_EXEC, 4'd4);
    bus.EXEC_DONE = 1'b1;
    step_expect("halt.idle", C_NONE, 4'd0);
    step_expect("idle.done", C_NONE, 4'd0);
    bus.EXEC_DONE = 1'b0;
    step_expect("idle.hold", C_NONE, 4'd0);

    // EXEC_DONE withheld: SC saturates and SC_OVF sticks
    bus.RUN = 1'b1;
    step_expect("ovf.t0", C_T0, 4'd0);
    step_expect("ovf.t1", C_T1, 4'd1);
    step_expect("ovf.t2", C_T2, 4'd2);
    step_expect("ovf.t3", C_NONE, 4'd3);
    for (int s = 4; s <= 17; s++) begin
      logic [3:0] exp_sc;
      exp_sc = (s > 15) ? 4'd15 : 4'(s);
      step_expect("ovf.exec", C_EXEC, exp_sc);
      check("ovf.flag", {15'h0000, bus.SC_OVF}, (s >= 15) ? 16'h0001 : 16'h0000);
    end
    bus.EXEC_DONE = 1'b1;
    bus.RUN       = 1'b0;
    step_expect("ovf.idle", C_NONE, 4'd0);
    check("ovf.sticky", {15'h0000, bus.SC_OVF}, 16'h0001);
    bus.EXEC_DONE = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
